// File: rtl/sram_arbiter.sv
// Two-port arbiter for a 1M x 16 async SRAM: VGA reads get priority,
// the CPU port is protected from starvation, and every access is fixed-length.
module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        vga_req,
  input  logic [19:0] vga_addr,
  output logic        vga_gnt,
  output logic [15:0] vga_rdata,
  output logic        vga_rvalid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic [1:0]  cpu_be,
  output logic        cpu_gnt,
  output logic [15:0] cpu_rdata,
  output logic        cpu_rvalid,
  inout  wire  [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_UB_N
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_TURN  = 2'd3;

  localparam logic [3:0] LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [7:0] SLIM = 8'(STARVE_LIMIT);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [7:0]  starve;
  logic        own_vga;
  logic        dq_oe;
  logic [15:0] dq_out;

  logic busy, last, launch_ok;
  logic vga_win, cpu_win, go_vga, go_cpu;

  assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

  always_comb begin
    busy      = (state == S_READ) || (state == S_WRITE);
    last      = busy && (cnt == LAST);
    launch_ok = (state == S_IDLE) || (state == S_TURN) || last;
    vga_win   = vga_req && !((starve == SLIM) && cpu_req);
    cpu_win   = !vga_win && cpu_req;
    go_vga    = launch_ok && vga_win;
    // a write right after a read waits one TURN cycle instead
    go_cpu    = launch_ok && cpu_win && !((state == S_READ) && cpu_we);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      starve     <= 8'd0;
      own_vga    <= 1'b0;
      dq_oe      <= 1'b0;
      dq_out     <= 16'd0;
      SRAM_ADDR  <= 20'd0;
      SRAM_CE_N  <= 1'b1;
      SRAM_OE_N  <= 1'b1;
      SRAM_WE_N  <= 1'b1;
      SRAM_LB_N  <= 1'b1;
      SRAM_UB_N  <= 1'b1;
      vga_gnt    <= 1'b0;
      cpu_gnt    <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;
      vga_rdata  <= 16'd0;
      cpu_rdata  <= 16'd0;
    end else begin
      vga_gnt    <= 1'b0;
      cpu_gnt    <= 1'b0;
      vga_rvalid <= 1'b0;
      cpu_rvalid <= 1'b0;

      if (last && (state == S_READ)) begin
        if (own_vga) begin
          vga_rdata  <= SRAM_DQ;
          vga_rvalid <= 1'b1;
        end else begin
          cpu_rdata  <= SRAM_DQ;
          cpu_rvalid <= 1'b1;
        end
      end

      if (busy && !last) begin
        cnt <= cnt + 4'd1;
        // first write cycle is address setup; WE falls after it
        if (state == S_WRITE)
          SRAM_WE_N <= 1'b0;
      end

      if (go_vga) begin
        state     <= S_READ;
        cnt       <= 4'd0;
        own_vga   <= 1'b1;
        SRAM_ADDR <= vga_addr;
        SRAM_CE_N <= 1'b0;
        SRAM_OE_N <= 1'b0;
        SRAM_WE_N <= 1'b1;
        SRAM_LB_N <= 1'b0;
        SRAM_UB_N <= 1'b0;
        dq_oe     <= 1'b0;
        vga_gnt   <= 1'b1;
      end else if (go_cpu) begin
        state     <= cpu_we ? S_WRITE : S_READ;
        cnt       <= 4'd0;
        own_vga   <= 1'b0;
        SRAM_ADDR <= cpu_addr;
        SRAM_CE_N <= 1'b0;
        SRAM_OE_N <= cpu_we;
        SRAM_WE_N <= 1'b1;
        SRAM_LB_N <= ~cpu_be[0];
        SRAM_UB_N <= ~cpu_be[1];
        dq_oe     <= cpu_we;
        dq_out    <= cpu_wdata;
        cpu_gnt   <= 1'b1;
      end else if (launch_ok) begin
        state     <= (cpu_win && (state == S_READ)) ? S_TURN : S_IDLE;
        SRAM_CE_N <= 1'b1;
        SRAM_OE_N <= 1'b1;
        SRAM_WE_N <= 1'b1;
        SRAM_LB_N <= 1'b1;
        SRAM_UB_N <= 1'b1;
        dq_oe     <= 1'b0;
      end

      if (!cpu_req || go_cpu)
        starve <= 8'd0;
      else if (go_vga && (starve != SLIM))
        starve <= starve + 8'd1;
    end
  end

endmodule
